// File: rtl/pmod_keypad_pkg.sv
// Shared definitions for the Pmod 4x4 keypad emulator and scanner benches:
// key codes, FSM state encoding, bounce LFSR constants and the key map.
package pmod_keypad_pkg;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_HASH = 4'hE;
  localparam logic [3:0] KEY_STAR = 4'hF;

  // Contact-bounce pattern source: 16-bit Galois LFSR
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } kp_state_e;

  // Map a key code to its matrix position, returned as {row[1:0], col[1:0]}
  function automatic logic [3:0] key_to_rc(input logic [3:0] code);
    logic [3:0] rc;
    case (code)
      KEY_1:    rc = {2'd0, 2'd0};
      KEY_4:    rc = {2'd1, 2'd0};
      KEY_7:    rc = {2'd2, 2'd0};
      KEY_STAR: rc = {2'd3, 2'd0};
      KEY_2:    rc = {2'd0, 2'd1};
      KEY_5:    rc = {2'd1, 2'd1};
      KEY_8:    rc = {2'd2, 2'd1};
      KEY_0:    rc = {2'd3, 2'd1};
      KEY_3:    rc = {2'd0, 2'd2};
      KEY_6:    rc = {2'd1, 2'd2};
      KEY_9:    rc = {2'd2, 2'd2};
      KEY_HASH: rc = {2'd3, 2'd2};
      KEY_A:    rc = {2'd0, 2'd3};
      KEY_B:    rc = {2'd1, 2'd3};
      KEY_C:    rc = {2'd2, 2'd3};
      KEY_D:    rc = {2'd3, 2'd3};
      default:  rc = 4'h0;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/pmod_keypad_emu_if.sv
// Key-press command port of the keypad emulator: valid/ready request plus
// busy and completion status.
interface pmod_keypad_emu_if;

  logic       press_valid;
  logic [3:0] press_key;
  logic       press_ready;
  logic       busy;
  logic       press_done;

  // Command source (bench or loopback controller)
  modport master (
    output press_valid,
    output press_key,
    input  press_ready,
    input  busy,
    input  press_done
  );

  // Keypad emulator side
  modport slave (
    input  press_valid,
    input  press_key,
    output press_ready,
    output busy,
    output press_done
  );

endinterface

// File: rtl/keypad_bounce_gen.sv
// Contact-bounce generator: after each start pulse the contact follows bit 0
// of a reseeded Galois LFSR for min(BOUNCE_CYCLES, HOLD_CYCLES) cycles, then
// stays closed. Used by pmod_keypad_emu only with PMOD_KEYPAD_BOUNCE_EN.
module keypad_bounce_gen
  import pmod_keypad_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 4096,
  parameter int unsigned HOLD_CYCLES   = 500000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic contact
);

  localparam int unsigned WIN_CYCLES =
    (BOUNCE_CYCLES < HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;

  logic [15:0]      r_lfsr;
  logic [15:0]      w_lfsr_step;
  logic [CNT_W-1:0] r_win;

  // One Galois shift: feedback taps applied when the output bit is 1
  always_comb begin
    w_lfsr_step = {1'b0, r_lfsr[15:1]};
    if (r_lfsr[0]) begin
      w_lfsr_step = w_lfsr_step ^ LFSR_POLY;
    end
  end

  // LFSR and bounce-window counter; start reseeds and rearms the window
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
      r_win  <= '0;
    end else if (start) begin
      r_lfsr <= LFSR_SEED;
      r_win  <= CNT_W'(WIN_CYCLES);
    end else begin
      r_lfsr <= w_lfsr_step;
      if (r_win != '0) begin
        r_win <= r_win - CNT_W'(1);
      end
    end
  end

  // Contact chatters while the window is open, clean afterwards
  always_comb begin
    contact = 1'b1;
    if (r_win != '0) begin
      contact = r_lfsr[0];
    end
  end

endmodule

// File: rtl/pmod_keypad_emu.sv
// Pmod 4x4 keypad emulator: the far end of a keypad scanner. Accepts one key
// press at a time, closes that key for HOLD_CYCLES, then forces a release gap
// of GAP_CYCLES before taking the next command. Rows answer the scanner's
// active-low column drive with zero latency.
// Optional contact bounce at press start: define PMOD_KEYPAD_BOUNCE_EN.
module pmod_keypad_emu
  import pmod_keypad_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 500000,
  parameter int unsigned GAP_CYCLES    = 250000,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned BOUNCE_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             col,
  output logic [3:0]             row,
  pmod_keypad_emu_if.slave       bus
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  =
    (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

  // Reject parameter sets the shared down-counter cannot represent
  if (HOLD_CYCLES == 0 || HOLD_CYCLES >= (32'd1 << CNT_W) ||
      GAP_CYCLES >= (32'd1 << CNT_W) || BOUNCE_CYCLES >= (32'd1 << CNT_W)) begin : g_bad_params
    $error("pmod_keypad_emu: HOLD/GAP/BOUNCE cycles out of range for CNT_W");
  end

  kp_state_e        r_state;
  kp_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  logic             w_done_nxt;
  logic [1:0]       r_key_row;
  logic [1:0]       r_key_col;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             w_contact;

  // State and hold/gap counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, counter load/decrement and command accept
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.press_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = HOLD;
          w_cnt_nxt   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          if (GAP_CYCLES == 0) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = GAP;
            w_cnt_nxt   = GAP_LOAD;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // Completion lands on the final cycle of the press sequence
    w_done_nxt = (w_cnt_nxt == '0) &&
                 ((w_state_nxt == GAP) || ((w_state_nxt == HOLD) && (GAP_CYCLES == 0)));
  end

  // Latched key position and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_row <= '0;
      r_key_col <= '0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_accept) begin
        {r_key_row, r_key_col} <= key_to_rc(bus.press_key);
      end
      r_ready <= (w_state_nxt == IDLE);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign bus.press_ready = r_ready;
  assign bus.busy        = r_busy;
  assign bus.press_done  = r_done;

`ifdef PMOD_KEYPAD_BOUNCE_EN
  keypad_bounce_gen #(
    .BOUNCE_CYCLES (BOUNCE_CYCLES),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .CNT_W         (CNT_W)
  ) u_bounce (
    .clk     (clk),
    .reset   (reset),
    .start   (w_accept),
    .contact (w_contact)
  );
`else
  assign w_contact = 1'b1;
`endif

  // Row answer: pressed key's row rises while its column is driven low
  always_comb begin
    row = 4'b0000;
    if ((r_state == HOLD) && w_contact && (col[r_key_col] == 1'b0)) begin
      row = 4'b0001 << r_key_row;
    end
  end

endmodule
